// File: rtl/cpu_multiciclo.sv
// Multicycle accumulator core: FETCH/DECODE/EXEC/MEM sequencing, R0 accumulator,
// Z/C flags with conditional jumps, and valid/ready stalls on the I/O ports.
module cpu_multiciclo #(
    parameter  int W      = 8,
    parameter  int REG_AW = 4,
    localparam int IW     = 4 + REG_AW + W
) (
    input  logic          clk,
    input  logic          rst,
    output logic [W-1:0]  imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [W-1:0]  dmem_addr,
    output logic [W-1:0]  dmem_wdata,
    output logic          dmem_we,
    input  logic [W-1:0]  dmem_rdata,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  seg_data,
    output logic [W-1:0]  pc,
    output logic          z_flag,
    output logic          c_flag
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, MEM} state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,  OP_LI    = 4'd1,  OP_LOAD  = 4'd2,  OP_STORE = 4'd3,
        OP_ADD   = 4'd4,  OP_SUB   = 4'd5,  OP_AND   = 4'd6,  OP_OR    = 4'd7,
        OP_XOR   = 4'd8,  OP_NOT   = 4'd9,  OP_LIN   = 4'd10, OP_PRINT = 4'd11,
        OP_SEG   = 4'd12, OP_JMP   = 4'd13, OP_JZ    = 4'd14, OP_JC    = 4'd15
    } op_t;

    localparam int NREG = 2 ** REG_AW;

    state_t            state;
    state_t            state_nx;
    logic [IW-1:0]     ir;
    logic [W-1:0]      regs [NREG];

    op_t               op;
    logic [REG_AW-1:0] rd;
    logic [W-1:0]      imm;
    logic [W-1:0]      acc;
    logic [W-1:0]      opnd;

    assign op   = op_t'(ir[IW-1 -: 4]);
    assign rd   = ir[W +: REG_AW];
    assign imm  = ir[W-1:0];
    assign acc  = regs[0];
    assign opnd = regs[rd];

    assign imem_addr = pc;

    // ALU: accumulator against R[rd]; carry doubles as borrow for SUB
    logic [W:0]   sum;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         alu_op;

    assign sum = {1'b0, acc} + {1'b0, opnd};

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the case statements can leave one unassigned (latch).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_op  = 1'b1;
        case (op)
            OP_ADD:  {alu_c, alu_res} = sum;
            OP_SUB: begin
                alu_res = acc - opnd;
                alu_c   = acc < opnd;
            end
            OP_AND:  alu_res = acc & opnd;
            OP_OR:   alu_res = acc | opnd;
            OP_XOR:  alu_res = acc ^ opnd;
            OP_NOT:  alu_res = ~opnd;
            default: alu_op  = 1'b0;
        endcase
    end

    // Sequencing and port decode; outputs depend on state and ir only
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        case (state)
            FETCH:  state_nx = DECODE;
            DECODE: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                case (op)
                    OP_LOAD: begin
                        dmem_addr = imm;
                        state_nx  = MEM;
                    end
                    OP_STORE: begin
                        dmem_addr  = imm;
                        dmem_wdata = opnd;
                        dmem_we    = 1'b1;
                    end
                    OP_LIN: begin
                        in_ready = 1'b1;
                        if (!in_valid) state_nx = EXEC;
                    end
                    OP_PRINT: begin
                        out_valid = 1'b1;
                        out_data  = opnd;
                        if (!out_ready) state_nx = EXEC;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                dmem_addr = imm;
                state_nx  = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    logic jump;

    always_comb begin
        jump = 1'b0;
        if (state == EXEC) begin
            case (op)
                OP_JMP:  jump = 1'b1;
                OP_JZ:   jump = z_flag;
                OP_JC:   jump = c_flag;
                default: jump = 1'b0;
            endcase
        end
    end

    // Register-file write port: one write per instruction at most
    logic              reg_we;
    logic [REG_AW-1:0] reg_wa;
    logic [W-1:0]      reg_wd;

    always_comb begin
        reg_we = 1'b0;
        reg_wa = rd;
        reg_wd = imm;
        if (state == EXEC) begin
            if (alu_op) begin
                reg_we = 1'b1;
                reg_wa = '0;
                reg_wd = alu_res;
            end else begin
                case (op)
                    OP_LI:  reg_we = 1'b1;
                    OP_LIN: begin
                        reg_we = in_valid;
                        reg_wd = in_data;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
        end else if (state == MEM) begin
            reg_we = 1'b1;
            reg_wd = dmem_rdata;
        end
    end

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
            seg_data <= '0;
            // NOTE: the register file is deliberately reset (flops, not a RAM
            // macro): programs rely on every register reading 0 after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE) begin
                ir <= imem_data;
                pc <= pc + W'(1);
            end
            if (jump) pc <= imm;
            if (reg_we) regs[reg_wa] <= reg_wd;
            if (state == EXEC && alu_op) begin
                z_flag <= (alu_res == '0);
                c_flag <= alu_c;
            end
            if (state == EXEC && op == OP_SEG) seg_data <= imm;
        end
    end

endmodule

// File: tb/tb_cpu_multiciclo.sv
// Bench for cpu_multiciclo: ROM/RAM models, PRINT scoreboard, directed programs
// on a W=8/REG_AW=4 core and a W=12/REG_AW=3 core.
module tb_cpu_multiciclo;

    localparam logic [3:0] O_NOP = 4'd0,  O_LI  = 4'd1,  O_LOAD = 4'd2,  O_STORE = 4'd3;
    localparam logic [3:0] O_ADD = 4'd4,  O_SUB = 4'd5,  O_XOR  = 4'd8,  O_LIN   = 4'd10;
    localparam logic [3:0] O_PRT = 4'd11, O_SEG = 4'd12, O_JMP  = 4'd13, O_JZ    = 4'd14;
    localparam logic [3:0] O_JC  = 4'd15;

    logic clk;
    logic rst8, rst12;

    logic [7:0]  imem_addr8, dmem_addr8, dmem_wdata8, dmem_rdata8, in_data8;
    logic [7:0]  out_data8, seg8, pc8;
    logic [19:0] imem_data8;
    logic        dmem_we8, in_valid8, in_ready8, out_valid8, out_ready8, z8, c8;

    logic [11:0] imem_addr12, dmem_addr12, dmem_wdata12, dmem_rdata12, in_data12;
    logic [11:0] out_data12, seg12, pc12;
    logic [18:0] imem_data12;
    logic        dmem_we12, in_valid12, in_ready12, out_valid12, out_ready12, z12, c12;

    logic [19:0] rom8  [256];
    logic [7:0]  ram8  [256];
    logic [18:0] rom12 [4096];
    logic [11:0] ram12 [4096];

    logic [7:0]  sb8  [$];
    logic [11:0] sb12 [$];

    int    n_cmp = 0;
    int    n_err = 0;
    int    we_cnt = 0;
    string phase = "reset";

    cpu_multiciclo #(.W(8), .REG_AW(4)) u8 (
        .clk(clk), .rst(rst8),
        .imem_addr(imem_addr8), .imem_data(imem_data8),
        .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8), .dmem_we(dmem_we8),
        .dmem_rdata(dmem_rdata8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
        .seg_data(seg8), .pc(pc8), .z_flag(z8), .c_flag(c8)
    );

    cpu_multiciclo #(.W(12), .REG_AW(3)) u12 (
        .clk(clk), .rst(rst12),
        .imem_addr(imem_addr12), .imem_data(imem_data12),
        .dmem_addr(dmem_addr12), .dmem_wdata(dmem_wdata12), .dmem_we(dmem_we12),
        .dmem_rdata(dmem_rdata12),
        .in_data(in_data12), .in_valid(in_valid12), .in_ready(in_ready12),
        .out_data(out_data12), .out_valid(out_valid12), .out_ready(out_ready12),
        .seg_data(seg12), .pc(pc12), .z_flag(z12), .c_flag(c12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM/RAM models, one cycle of read latency
    always @(posedge clk) begin
        imem_data8 <= rom8[imem_addr8];
        if (dmem_we8) ram8[dmem_addr8] <= dmem_wdata8;
        dmem_rdata8 <= ram8[dmem_addr8];
        imem_data12 <= rom12[imem_addr12];
        if (dmem_we12) ram12[dmem_addr12] <= dmem_wdata12;
        dmem_rdata12 <= ram12[dmem_addr12];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: pop one expected value per completed PRINT transfer
    always @(negedge clk) begin
        if (rst8 && out_valid8 && out_ready8) begin
            check({phase, ".sb_nonempty"}, sb8.size() != 0, 1'b1);
            if (sb8.size() != 0) check({phase, ".print"}, out_data8, sb8.pop_front());
        end
        if (rst12 && out_valid12 && out_ready12) begin
            check("u12.sb_nonempty", sb12.size() != 0, 1'b1);
            if (sb12.size() != 0) check("u12.print", out_data12, sb12.pop_front());
        end
        if (rst8 && dmem_we8) begin
            we_cnt++;
            check({phase, ".st_addr"}, dmem_addr8, 8'h10);
            check({phase, ".st_wdata"}, dmem_wdata8, 8'h6B);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [19:0] i8(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [18:0] i12(input logic [3:0] op, input logic [2:0] rd, input logic [11:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rom8();
        for (int i = 0; i < 256; i++) rom8[i] = i8(O_NOP, 4'd0, 8'd0);
    endtask

    task automatic release_rst8();
        repeat (2) @(posedge clk);
        #2 rst8 = 1'b1;
    endtask

    // kind 0: pc8==val, 1: in_ready8, otherwise out_valid8; sampled on negedges
    task automatic wait_for(input int kind, input logic [7:0] val, input int budget, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (kind)
                0:       hit = (pc8 == val);
                1:       hit = in_ready8;
                default: hit = out_valid8;
            endcase
            if (hit) break;
        end
        check(tag, hit, 1'b1);
    endtask

    initial begin
        int edge_at;
        int cnt;
        bit hit;

        rst8 = 1'b1; rst12 = 1'b1;
        in_data8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        in_data12 = '0; in_valid12 = 1'b0; out_ready12 = 1'b1;
        for (int i = 0; i < 256; i++) ram8[i] = '0;
        for (int i = 0; i < 4096; i++) begin
            rom12[i] = '0;
            ram12[i] = '0;
        end
        clear_rom8();
        #3;
        rst8 = 1'b0; rst12 = 1'b0;
        #1;
        check("rst.pc", pc8, 0);
        check("rst.imem_addr", imem_addr8, 0);
        check("rst.out_valid", out_valid8, 0);
        check("rst.out_data", out_data8, 0);
        check("rst.in_ready", in_ready8, 0);
        check("rst.dmem_we", dmem_we8, 0);
        check("rst.seg", seg8, 0);
        check("rst.zc", {z8, c8}, 2'b00);

        // LI R0,5; LI R1,3; ADD R1; PRINT R0
        phase = "basic";
        rom8[0] = i8(O_LI, 4'd0, 8'd5);
        rom8[1] = i8(O_LI, 4'd1, 8'd3);
        rom8[2] = i8(O_ADD, 4'd1, 8'd0);
        rom8[3] = i8(O_PRT, 4'd0, 8'd0);
        rom8[4] = i8(O_JMP, 4'd0, 8'd4);
        sb8.push_back(8'd8);
        release_rst8();
        // First edge after release is cycle 0 (the fetch); PRINT's EXEC opens at cycle 10
        edge_at = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid8) begin
                edge_at = e;
                break;
            end
        end
        check("basic.print_cycle", edge_at, 11);
        @(negedge clk);
        check("basic.valid_1cyc", out_valid8, 0);
        check("basic.zc", {z8, c8}, 2'b00);

        // Flags and conditional jumps
        step(); rst8 = 1'b0; phase = "flags";
        clear_rom8();
        rom8[8'h00] = i8(O_LI, 4'd0, 8'hF0);
        rom8[8'h01] = i8(O_LI, 4'd2, 8'h20);
        rom8[8'h02] = i8(O_ADD, 4'd2, 8'h00);
        rom8[8'h03] = i8(O_JC, 4'd0, 8'h40);
        rom8[8'h40] = i8(O_PRT, 4'd0, 8'h00);
        rom8[8'h41] = i8(O_SUB, 4'd2, 8'h00);
        rom8[8'h42] = i8(O_PRT, 4'd0, 8'h00);
        rom8[8'h43] = i8(O_XOR, 4'd0, 8'h00);
        rom8[8'h44] = i8(O_PRT, 4'd0, 8'h00);
        rom8[8'h45] = i8(O_JZ, 4'd0, 8'h47);
        rom8[8'h46] = i8(O_PRT, 4'd2, 8'h00);
        rom8[8'h47] = i8(O_JC, 4'd0, 8'h46);
        rom8[8'h48] = i8(O_JMP, 4'd0, 8'h48);
        sb8.push_back(8'h10);
        sb8.push_back(8'hF0);
        sb8.push_back(8'h00);
        release_rst8();
        wait_for(0, 8'h40, 60, "flags.jc_taken");
        check("flags.add_zc", {z8, c8}, 2'b01);
        wait_for(0, 8'h43, 60, "flags.reach_43");
        check("flags.sub_zc", {z8, c8}, 2'b01);
        wait_for(0, 8'h45, 60, "flags.reach_45");
        check("flags.xor_zc", {z8, c8}, 2'b10);
        wait_for(0, 8'h49, 60, "flags.halt");
        @(negedge clk);
        check("flags.halt_jump", pc8, 8'h48);
        repeat (2) @(negedge clk);
        check("flags.halt_loop", pc8, 8'h49);
        check("flags.sb_drain", sb8.size(), 0);

        // LIN stall: in_valid low for five cycles, then one transfer
        step(); rst8 = 1'b0; phase = "lin";
        clear_rom8();
        rom8[0] = i8(O_PRT, 4'd3, 8'd0);
        rom8[1] = i8(O_LIN, 4'd3, 8'd0);
        rom8[2] = i8(O_PRT, 4'd3, 8'd0);
        rom8[3] = i8(O_JMP, 4'd0, 8'd3);
        sb8.push_back(8'h00);
        sb8.push_back(8'hA5);
        in_data8 = 8'h5A;
        release_rst8();
        wait_for(1, 8'h00, 60, "lin.ready_seen");
        cnt = 1;
        check("lin.stall_pc0", pc8, 8'd2);
        repeat (4) begin
            @(posedge clk);
            #2 in_data8 = 8'($urandom);
            @(negedge clk);
            cnt += int'(in_ready8);
        end
        check("lin.stall_pc", pc8, 8'd2);
        @(posedge clk);
        #2;
        in_valid8 = 1'b1;
        in_data8  = 8'hA5;
        @(negedge clk);
        cnt += int'(in_ready8);
        @(posedge clk);
        #2;
        in_valid8 = 1'b0;
        in_data8  = 8'h00;
        @(negedge clk);
        check("lin.ready_drop", in_ready8, 0);
        check("lin.ready_cycles", cnt, 6);
        wait_for(0, 8'h04, 60, "lin.halt");
        check("lin.sb_drain", sb8.size(), 0);

        // STORE/LOAD timing, PRINT7SEG hold, ADD R0 doubling
        step(); rst8 = 1'b0; phase = "mem";
        clear_rom8();
        rom8[0] = i8(O_LI, 4'd1, 8'h6B);
        rom8[1] = i8(O_STORE, 4'd1, 8'h10);
        rom8[2] = i8(O_LOAD, 4'd4, 8'h10);
        rom8[3] = i8(O_PRT, 4'd4, 8'h00);
        rom8[4] = i8(O_SEG, 4'd0, 8'h3C);
        rom8[5] = i8(O_LI, 4'd0, 8'h01);
        rom8[6] = i8(O_ADD, 4'd0, 8'h00);
        rom8[7] = i8(O_PRT, 4'd0, 8'h00);
        rom8[8] = i8(O_JMP, 4'd0, 8'h08);
        sb8.push_back(8'h6B);
        sb8.push_back(8'h02);
        we_cnt = 0;
        release_rst8();
        wait_for(0, 8'h02, 60, "mem.store_exec");
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pc8 != 8'h02) break;
            cnt++;
        end
        check("mem.store_cycles", cnt, 3);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pc8 != 8'h03) break;
            cnt++;
        end
        check("mem.load_cycles", cnt, 4);
        check("mem.seg_before", seg8, 8'h00);
        wait_for(0, 8'h09, 60, "mem.halt");
        check("mem.seg_held", seg8, 8'h3C);
        check("mem.we_cycles", we_cnt, 1);
        check("mem.sb_drain", sb8.size(), 0);

        // pc wrap 0xFF -> 0x00
        step(); rst8 = 1'b0; phase = "wrap";
        clear_rom8();
        rom8[8'h00] = i8(O_JMP, 4'd0, 8'hFF);
        release_rst8();
        wait_for(0, 8'hFF, 60, "wrap.reach_ff");
        repeat (2) @(negedge clk);
        check("wrap.pc_zero", pc8, 8'h00);
        @(negedge clk);
        check("wrap.fetch_zero", imem_addr8, 8'h00);
        repeat (2) @(negedge clk);
        check("wrap.refetch_jmp", pc8, 8'h01);

        // Reset during a PRINT stall
        step(); rst8 = 1'b0; phase = "rststall";
        clear_rom8();
        rom8[0] = i8(O_PRT, 4'd6, 8'h00);
        rom8[1] = i8(O_LI, 4'd6, 8'h77);
        rom8[2] = i8(O_LI, 4'd0, 8'h81);
        rom8[3] = i8(O_SEG, 4'd0, 8'h55);
        rom8[4] = i8(O_ADD, 4'd0, 8'h00);
        rom8[5] = i8(O_PRT, 4'd0, 8'h00);
        rom8[6] = i8(O_JMP, 4'd0, 8'h06);
        sb8.push_back(8'h00);
        out_ready8 = 1'b1;
        release_rst8();
        wait_for(0, 8'h02, 60, "rststall.first_print");
        step();
        out_ready8 = 1'b0;
        wait_for(2, 8'h00, 60, "rststall.valid_seen");
        repeat (3) begin
            @(negedge clk);
            check("rststall.valid_hold", out_valid8, 1);
            check("rststall.data_hold", out_data8, 8'h02);
        end
        check("rststall.pre_pc", pc8, 8'h06);
        check("rststall.pre_seg", seg8, 8'h55);
        check("rststall.pre_zc", {z8, c8}, 2'b01);
        step();
        rst8 = 1'b0;
        #1;
        check("rststall.valid_drop", out_valid8, 0);
        check("rststall.data_drop", out_data8, 0);
        check("rststall.pc", pc8, 0);
        check("rststall.seg", seg8, 0);
        check("rststall.zc", {z8, c8}, 2'b00);
        out_ready8 = 1'b1;
        sb8.push_back(8'h00);
        sb8.push_back(8'h02);
        release_rst8();
        wait_for(0, 8'h07, 60, "rststall.halt");
        check("rststall.sb_drain", sb8.size(), 0);

        // Same reset-in-stall scenario on the W=12, REG_AW=3 core
        rst8 = 1'b0;
        phase = "u12";
        rom12[0] = i12(O_LI, 3'd0, 12'hABC);
        rom12[1] = i12(O_LI, 3'd5, 12'h678);
        rom12[2] = i12(O_ADD, 3'd5, 12'h000);
        rom12[3] = i12(O_SEG, 3'd0, 12'h9F1);
        rom12[4] = i12(O_PRT, 3'd0, 12'h000);
        rom12[5] = i12(O_JMP, 3'd0, 12'h005);
        out_ready12 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst12 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid12) begin
                hit = 1'b1;
                break;
            end
        end
        check("u12.valid_seen", hit, 1'b1);
        check("u12.data", out_data12, 12'h134);
        check("u12.zc", {z12, c12}, 2'b01);
        check("u12.seg", seg12, 12'h9F1);
        check("u12.pc", pc12, 12'h005);
        step();
        rst12 = 1'b0;
        #1;
        check("u12.rst_valid", out_valid12, 0);
        check("u12.rst_pc", pc12, 0);
        check("u12.rst_seg", seg12, 0);
        check("u12.rst_zc", {z12, c12}, 2'b00);
        out_ready12 = 1'b1;
        sb12.push_back(12'h134);
        repeat (2) @(posedge clk);
        #2 rst12 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pc12 == 12'h006) begin
                hit = 1'b1;
                break;
            end
        end
        check("u12.halt", hit, 1'b1);
        check("u12.sb_drain", sb12.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_multiciclo.md
# cpu_multiciclo

Parametrised multicycle accumulator processor, successor to the single-cycle 8-bit core. It keeps the same 4-bit opcode map and the R0-as-accumulator model. It adds:
- configurable data/PC width and register count
- Z/C flags with conditional jumps
- valid/ready handshakes on the input and output ports, which stall the core instead of sampling blindly

It sits between the board top level (switches, LEDs, seg7 decoders) and external synchronous program ROM and data RAM.

## Interface
- W, 8: data width = PC width = immediate width; ≥4
- REG_AW, 4: register-address bits; 2**REG_AW registers, R0 = accumulator
- IW (derived, not overridable): 4 + REG_AW + W, instruction width; instr = {op[3:0], rd[REG_AW-1:0], imm[W-1:0]}

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- imem_addr  output  W  program ROM address (= pc)
- imem_data  input  IW  program ROM word, valid 1 cycle after address
- dmem_addr  output  W  data RAM address
- dmem_wdata  output  W  data RAM write data
- dmem_we  output  1  data RAM write enable
- dmem_rdata  input  W  data RAM read data, 1-cycle latency
- in_data  input  W  external input (switches)
- in_valid  input  1  in_data valid
- in_ready  output  1  core consuming in_data this cycle
- out_data  output  W  output value (LEDs)
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data
- seg_data  output  W  registered 7-seg value, raw hex nibbles
- pc  output  W  current program counter (debug/LEDR)
- z_flag, c_flag  output  1 each  ALU flags

## Operation
- State machine, states FETCH, DECODE, EXEC, MEM.
  - FETCH: drive imem_addr=pc, then go to DECODE.
  - DECODE: ir <= imem_data; pc <= pc+1 (wraps 2**W-1 -> 0); go to EXEC.
  - EXEC: execute the opcode. Go to MEM for LOAD; otherwise go to FETCH unless stalled.
  - MEM: R[rd] <= dmem_rdata, then go to FETCH.
- Opcodes:
  - 0 NOP
  - 1 LI: R[rd] <= imm
  - 2 LOAD: dmem_addr=imm; R[rd] <= dmem_rdata in MEM
  - 3 STORE: dmem_addr=imm, dmem_wdata=R[rd], dmem_we=1 for the single EXEC cycle
  - 4 ADD: {C,R0} <= R0+R[rd] (W+1-bit sum)
  - 5 SUB: R0 <= R0-R[rd] mod 2**W; C=1 iff R0<R[rd] (borrow)
  - 6 AND, 7 OR, 8 XOR: R0 <= R0 op R[rd]; C <= 0
  - 9 NOT: R0 <= ~R[rd]; C <= 0
  - 10 LIN: in_ready=1; when in_valid=1, R[rd] <= in_data; otherwise stall in EXEC
  - 11 PRINT: out_valid=1, out_data=R[rd]; stall in EXEC until out_ready=1
  - 12 PRINT7SEG: seg_data <= imm (held until the next PRINT7SEG or reset)
  - 13 JMP: pc <= imm
  - 14 JZ: pc <= imm if Z
  - 15 JC: pc <= imm if C
- Flags:
  - Z <= (result==0) on opcodes 4–9 only.
  - All other opcodes leave Z/C unchanged.
- The rd=0 operand form is legal: ADD R0 doubles R0, LI R0 loads the accumulator.
- Jump taken in EXEC overrides the DECODE increment. A jump to the current instruction gives a 3-cycle infinite loop (halt idiom).
- Combinational outputs (in_ready, out_valid, out_data, dmem_*) are decoded from state and ir only. There is no combinational path from any input to any output.
- Outside their instruction, dmem_we/in_ready/out_valid = 0 and dmem_addr/dmem_wdata/out_data = 0.

## Timing
- Reset (rst=0, async): state=FETCH, pc=0, ir=0, all registers 0, Z=C=0, seg_data=0, and every output 0. First fetch is at the first rising edge after rst deasserts.
- Cycles per instruction:
  - 3: NOP, LI, STORE, ALU, PRINT7SEG, jumps
  - 4: LOAD
  - LIN/PRINT: 3 + stall cycles
- Handshake transfer occurs on the edge where valid&ready=1.
  - in_valid may be held or toggled freely; only the transfer edge samples in_data.
  - out_valid/out_data stay stable until transfer.
- Register writes, flag updates and pc loads take effect at the end of EXEC (or MEM). They are visible to the next instruction's EXEC.
- Reset during a stall drops in_ready/out_valid immediately (asynchronously); no transfer is counted.

## Test plan
- Reset, then program LI R0,5; LI R1,3; ADD R1; PRINT R0 with out_ready=1 -> out_data=8, valid for 1 cycle, Z=0, C=0; PRINT EXEC begins cycle 10 after reset.
- W=8: LI R0,0xF0; LI R2,0x20; ADD R2; JC to 0x40 -> R0=0x10, C=1, pc=0x40. SUB R2 with R0=0x10 -> R0=0xF0, C=1. XOR R0 -> R0=0, Z=1, C=0.
- LIN R3 with in_valid low for 5 cycles, then in_data=0xA5 -> in_ready high 6 cycles; R3=0xA5 only after the transfer; pc does not advance during the stall.
- STORE R1,0x10 then LOAD R4,0x10 -> dmem_we high exactly 1 cycle; R4 equals R1; LOAD takes 4 cycles.
- pc wrap: NOP at 0xFF -> next fetch at 0x00. PRINT7SEG 0x3C -> seg_data=0x3C held across later instructions.
- Assert rst mid-PRINT stall -> out_valid low asynchronously; pc/regs/flags/seg_data = 0; execution restarts at 0. Repeat with W=12, REG_AW=3.
